spike_aer_encoder: RTL

- Sits directly downstream of a row of neuron_lif instances and consumes their is_spike outputs once per timestep.
- Each timestep's spike vector is latched, then scanned lowest-index-first.
- Each spike is emitted as an address-event (neuron index, timestep, last-of-step flag) through a small FIFO with a valid/ready output.
- Decouples neuron timestep evaluation from a slower serial output or next-layer consumer.

---
 rtl/spike_aer_encoder_if.sv | 31 +++
 rtl/spike_aer_encoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/spike_aer_encoder_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// spike_aer_encoder_if : timestep-in / address-event-out bundle   rev 1.0
// ------------------------------------------------------------------------
interface spike_aer_encoder_if #(
  parameter int NEURONS       = 8,
  parameter int ADDR_BITS     = $clog2(NEURONS),
  parameter int TIMESTEP_BITS = 8
);
  logic                     step_valid;
  logic [NEURONS-1:0]       spikes;
  logic                     step_ready;
  logic                     aer_valid;
  logic                     aer_ready;
  logic [ADDR_BITS-1:0]     aer_addr;
  logic [TIMESTEP_BITS-1:0] aer_timestep;
  logic                     aer_last;
  logic [TIMESTEP_BITS-1:0] timestep;

  // master = the encoder (event source), slave = neuron row plus event consumer
  modport master (
    input  step_valid, spikes, aer_ready,
    output step_ready, aer_valid, aer_addr, aer_timestep, aer_last, timestep
  );

  modport slave (
    output step_valid, spikes, aer_ready,
    input  step_ready, aer_valid, aer_addr, aer_timestep, aer_last, timestep
  );
endinterface
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// spike_aer_encoder : latches a spike vector, emits one AER event per spike  rev 1.0
// ------------------------------------------------------------------------
module spike_aer_encoder #(
  parameter int NEURONS       = 8,
  parameter int ADDR_BITS     = $clog2(NEURONS),
  parameter int TIMESTEP_BITS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  spike_aer_encoder_if.master bus
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] c_DEPTH = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                   r_state;
  logic [NEURONS-1:0]       r_pending;
  logic [TIMESTEP_BITS-1:0] r_step_ts;
  logic [TIMESTEP_BITS-1:0] r_timestep;

  logic [ADDR_BITS-1:0]     r_mem_addr [FIFO_DEPTH];
  logic [TIMESTEP_BITS-1:0] r_mem_ts   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_mem_last;
  logic [PTR_BITS-1:0]      r_wr_ptr;
  logic [PTR_BITS-1:0]      r_rd_ptr;
  logic [CNT_BITS-1:0]      r_count;

  logic [ADDR_BITS-1:0]     w_idx;
  logic [NEURONS-1:0]       w_pending_next;
  logic                     w_last;
  logic                     w_pop;
  logic                     w_push;

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    w_idx = '0;
    for (int i = NEURONS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = ADDR_BITS'(i);
    end
  end

  assign w_pending_next = r_pending & (r_pending - NEURONS'(1));
  assign w_last         = (w_pending_next == '0);
  assign w_pop          = (r_count != '0) && bus.aer_ready;
  assign w_push         = (r_state == S_SCAN) && ((r_count != c_DEPTH) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_step_ts  <= '0;
      r_timestep <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mem_last <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem_addr[k] <= '0;
        r_mem_ts[k]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.step_valid) begin
            r_pending  <= bus.spikes;
            r_step_ts  <= r_timestep;
            r_timestep <= r_timestep + TIMESTEP_BITS'(1);
            if (bus.spikes != '0) r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_push) begin
            r_pending <= w_pending_next;
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_mem_addr[r_wr_ptr] <= w_idx;
        r_mem_ts[r_wr_ptr]   <= r_step_ts;
        r_mem_last[r_wr_ptr] <= w_last;
        r_wr_ptr             <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);

      // A push and pop on the same edge leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.step_ready   = (r_state == S_IDLE);
  assign bus.aer_valid    = (r_count != '0);
  assign bus.aer_addr     = r_mem_addr[r_rd_ptr];
  assign bus.aer_timestep = r_mem_ts[r_rd_ptr];
  assign bus.aer_last     = r_mem_last[r_rd_ptr];
  assign bus.timestep     = r_timestep;

endmodule
`default_nettype wire
